// File: rtl/seg_pkg.sv
// Shared 7-segment glyph definitions (active-high, bit 6 = a ... bit 0 = g).
package seg_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CODE_W = 4;

  typedef logic [SEG_W-1:0]  glyph_t;
  typedef logic [CODE_W-1:0] code_t;

  localparam glyph_t GLYPH_0    = 7'b1111110;
  localparam glyph_t GLYPH_1    = 7'b0110000;
  localparam glyph_t GLYPH_2    = 7'b1101101;
  localparam glyph_t GLYPH_3    = 7'b1111001;
  localparam glyph_t GLYPH_4    = 7'b0110011;
  localparam glyph_t GLYPH_5    = 7'b1011011;
  localparam glyph_t GLYPH_6    = 7'b1011111;
  localparam glyph_t GLYPH_7    = 7'b1110010;
  localparam glyph_t GLYPH_8    = 7'b1111111;
  localparam glyph_t GLYPH_9    = 7'b1111011;
  localparam glyph_t GLYPH_A    = 7'b1110111;
  localparam glyph_t GLYPH_B    = 7'b0011111;
  localparam glyph_t GLYPH_C    = 7'b1001110;
  localparam glyph_t GLYPH_D    = 7'b0111101;
  localparam glyph_t GLYPH_E    = 7'b1001111;
  localparam glyph_t GLYPH_F    = 7'b1000111;
  localparam glyph_t GLYPH_DASH = 7'b0000001;
  localparam glyph_t SEG_OFF    = 7'b0000000;

  // Codes above 9 fall back to a dash unless hex glyphs are enabled.
  function automatic glyph_t code_to_glyph(input code_t code, input logic hex_en);
    glyph_t g;
    g = GLYPH_DASH;
    case (code)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = hex_en ? GLYPH_A : GLYPH_DASH;
      4'hB: g = hex_en ? GLYPH_B : GLYPH_DASH;
      4'hC: g = hex_en ? GLYPH_C : GLYPH_DASH;
      4'hD: g = hex_en ? GLYPH_D : GLYPH_DASH;
      4'hE: g = hex_en ? GLYPH_E : GLYPH_DASH;
      default: g = hex_en ? GLYPH_F : GLYPH_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_enc.sv
// Combinational code-to-segment encoder with dark override and output polarity.
module seg7_enc
  import seg_pkg::*;
#(
  parameter int unsigned HEX_EN      = 0,
  parameter int unsigned SEG_ACT_LOW = 1
) (
  input  logic [CODE_W-1:0] code,
  input  logic              dark,
  output logic [SEG_W-1:0]  seg_c
);

  glyph_t glyph_c;

  always_comb begin
    glyph_c = dark ? SEG_OFF : code_to_glyph(code, HEX_EN != 0);
    seg_c   = (SEG_ACT_LOW != 0) ? ~glyph_c : glyph_c;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scanner: guard-cycle digit sequencing, blink/blank/dp
// masks and leading-zero blanking, all outputs registered.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned HEX_EN       = 0,
  parameter int unsigned SEG_ACT_LOW  = 1,
  parameter int unsigned COM_ACT_LOW  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [CODE_W*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]        blank_mask,
  input  logic [NUM_DIGITS-1:0]        blink_mask,
  input  logic [NUM_DIGITS-1:0]        dp_mask,
  input  logic                         lzb,
  output logic [SEG_W-1:0]             seg,
  output logic                         dp,
  output logic [NUM_DIGITS-1:0]        com
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [SEG_W-1:0]      SEG_IDLE = (SEG_ACT_LOW != 0) ? '1 : '0;
  localparam logic                  DP_IDLE  = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] COM_IDLE = (COM_ACT_LOW != 0) ? '1 : '0;

  logic [PW-1:0] pcnt, pcnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic          blink_off, blink_off_nxt;

  logic [CODE_W-1:0]     codes [NUM_DIGITS];
  logic [CODE_W-1:0]     code_c;
  logic                  lz_c;
  logic                  dark_c;
  logic                  dp_lit_c;
  logic [NUM_DIGITS-1:0] onehot_c;
  logic [SEG_W-1:0]      seg_nxt_c;
  logic                  dp_nxt_c;
  logic [NUM_DIGITS-1:0] com_nxt_c;

  // Scan counters: slot timer, digit index, frame counter, blink phase.
  always_comb begin
    pcnt_nxt      = pcnt;
    idx_nxt       = idx;
    fcnt_nxt      = fcnt;
    blink_off_nxt = blink_off;
    if (!en) begin
      pcnt_nxt      = '0;
      idx_nxt       = '0;
      fcnt_nxt      = '0;
      blink_off_nxt = 1'b0;
    end else if (pcnt == PCNT_LAST) begin
      pcnt_nxt = '0;
      if (idx == IDX_LAST) begin
        idx_nxt = '0;
        if (fcnt == FCNT_LAST) begin
          fcnt_nxt      = '0;
          blink_off_nxt = ~blink_off;
        end else begin
          fcnt_nxt = fcnt + FW'(1);
        end
      end else begin
        idx_nxt = idx + IW'(1);
      end
    end else begin
      pcnt_nxt = pcnt + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt      <= '0;
      idx       <= '0;
      fcnt      <= '0;
      blink_off <= 1'b0;
    end else begin
      pcnt      <= pcnt_nxt;
      idx       <= idx_nxt;
      fcnt      <= fcnt_nxt;
      blink_off <= blink_off_nxt;
    end
  end

  // A digit is lz-blanked only when it and every more-significant digit are zero.
  always_comb begin
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      codes[k] = digits[CODE_W*k +: CODE_W];
    end
    code_c = codes[idx];
    lz_c   = lzb && (idx != '0);
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if ((k >= int'(idx)) && (codes[k] != '0)) lz_c = 1'b0;
    end
  end

  // Guard cycle and disable reuse the dark path so the encoder drives the off pattern.
  always_comb begin
    dark_c   = !en || (pcnt == '0) || blank_mask[idx] ||
               (blink_mask[idx] && blink_off) || lz_c;
    dp_lit_c = dp_mask[idx] && !dark_c;
    dp_nxt_c = (SEG_ACT_LOW != 0) ? !dp_lit_c : dp_lit_c;
    onehot_c = NUM_DIGITS'(1) << idx;
    if (!en || (pcnt == '0)) begin
      com_nxt_c = COM_IDLE;
    end else begin
      com_nxt_c = (COM_ACT_LOW != 0) ? ~onehot_c : onehot_c;
    end
  end

  seg7_enc #(
    .HEX_EN      (HEX_EN),
    .SEG_ACT_LOW (SEG_ACT_LOW)
  ) u_enc (
    .code  (code_c),
    .dark  (dark_c),
    .seg_c (seg_nxt_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_IDLE;
      dp  <= DP_IDLE;
      com <= COM_IDLE;
    end else begin
      seg <= seg_nxt_c;
      dp  <= dp_nxt_c;
      com <= com_nxt_c;
    end
  end

endmodule
